// File: rtl/ppf_commutator_seq.sv
// Polyphase filterbank input commutator: steps samples across branches R-1..0,
// one frame per R samples, with frame-boundary ratio updates and FIR backpressure.
module ppf_commutator_seq #(
  parameter int unsigned MAX_BRANCH = 64,
  parameter int unsigned DEF_RATIO  = 8,
  parameter int unsigned IDX_W      = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [9:0]       cfg_ratio_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic             fir_busy_i,
  output logic             branch_we_o,
  output logic [IDX_W-1:0] branch_idx_o,
  output logic             frame_done_o,
  output logic [15:0]      frame_cnt_o
);

  // Ratio registers are one bit wider than the index so MAX_BRANCH itself fits.
  localparam int unsigned RW = IDX_W + 1;

  typedef enum logic [1:0] {StIdle, StRun, StSync} state_e;

  state_e           state_q, state_d;
  logic [RW-1:0]    ratio_q, ratio_d;
  logic [RW-1:0]    pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] widx_q, widx_d;
  logic             we_q, we_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [15:0]      cnt_q, cnt_d;

  logic hs, last_hs, cfg_hs, cfg_in_range, cfg_ok;

  assign hs           = s_valid_i & s_ready_o;
  assign last_hs      = hs & (idx_q == '0);
  assign cfg_hs       = cfg_valid_i & ~pend_v_q;
  assign cfg_in_range = (cfg_ratio_i >= 10'd2) && (32'(cfg_ratio_i) <= MAX_BRANCH);
  assign cfg_ok       = cfg_hs & cfg_in_range;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (!pend_v_q && en_i) state_d = StRun;
      // A config landing on the branch-0 handshake must also break the run.
      StRun:  if (last_hs && (fir_busy_i || pend_v_q || !en_i || cfg_ok)) state_d = StSync;
      StSync: if (!fir_busy_i) state_d = en_i ? StRun : StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ratio_d  = ratio_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    err_d    = err_q;
    we_d     = hs;
    widx_d   = idx_q;
    done_d   = last_hs;
    cnt_d    = cnt_q + 16'(last_hs);

    unique case (state_q)
      StIdle: begin
        if (pend_v_q) begin
          ratio_d  = pend_q;
          pend_v_d = 1'b0;
        end else if (en_i) begin
          idx_d = IDX_W'(ratio_q - 1'b1);
        end
      end
      StRun: begin
        if (hs) begin
          idx_d = (idx_q != '0) ? idx_q - 1'b1 : IDX_W'(ratio_q - 1'b1);
        end
      end
      StSync: begin
        if (!fir_busy_i) begin
          if (pend_v_q) begin
            ratio_d  = pend_q;
            pend_v_d = 1'b0;
            idx_d    = IDX_W'(pend_q - 1'b1);
          end else begin
            idx_d = IDX_W'(ratio_q - 1'b1);
          end
        end
      end
      default: ;
    endcase

    if (cfg_ok) begin
      pend_d   = RW'(cfg_ratio_i);
      pend_v_d = 1'b1;
      err_d    = 1'b0;
    end else if (cfg_hs) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ratio_q  <= RW'(DEF_RATIO);
      pend_q   <= '0;
      pend_v_q <= 1'b0;
      idx_q    <= '0;
      widx_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      ratio_q  <= ratio_d;
      pend_q   <= pend_d;
      pend_v_q <= pend_v_d;
      idx_q    <= idx_d;
      widx_q   <= widx_d;
      we_q     <= we_d;
      done_q   <= done_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    s_ready_o    = (state_q == StRun);
    cfg_ready_o  = ~pend_v_q;
    cfg_err_o    = err_q;
    branch_we_o  = we_q;
    branch_idx_o = widx_q;
    frame_done_o = done_q;
    frame_cnt_o  = cnt_q;
  end

endmodule
